// File: rtl/instr_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : instr_buf_pkg                                                 |
// | Purpose    : Shared types and constants for the fetch-to-decode            |
// |              instruction buffer.                                           |
// | Contents   : XLEN, DEFAULT_DEPTH, fetch_entry_t {pc, pc4, instr}.          |
// | Config     : none (INSTR_BUF_PERF_EN is consumed by instr_buffer).         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package instr_buf_pkg;

   localparam int XLEN          = 32;
   localparam int DEFAULT_DEPTH = 2;

   // One buffered fetch: the word plus the fetch state decode needs.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage : instr_buf_pkg
`default_nettype wire

// File: rtl/instr_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : instr_buf_if                                                  |
// | Purpose    : Fetch-side and decode-side signals of the instruction buffer. |
// | Modports   : slave  - the buffer (consumes fetch/flush/ready, drives       |
// |                       hold, decode head, overflow and perf counters)       |
// |              master - the surrounding pipeline / environment               |
// | Signals    : fetch_valid_i, fetch_pc_i, fetch_pc4_i, mem_rdata_i,          |
// |              flush_i, dec_ready_i, fetch_hold_o, dec_valid_o, dec_instr_o, |
// |              dec_pc_o, dec_pc4_o, overflow_o, perf_hold_cnt_o,             |
// |              perf_flush_cnt_o                                              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface instr_buf_if;
   import instr_buf_pkg::*;

   // fetch side
   logic            fetch_valid_i;
   logic [XLEN-1:0] fetch_pc_i;
   logic [XLEN-1:0] fetch_pc4_i;
   logic [XLEN-1:0] mem_rdata_i;
   logic            fetch_hold_o;
   logic            flush_i;

   // decode side
   logic            dec_valid_o;
   logic            dec_ready_i;
   logic [XLEN-1:0] dec_instr_o;
   logic [XLEN-1:0] dec_pc_o;
   logic [XLEN-1:0] dec_pc4_o;

   // status
   logic            overflow_o;
   logic [31:0]     perf_hold_cnt_o;
   logic [31:0]     perf_flush_cnt_o;

   modport slave (
      input  fetch_valid_i, fetch_pc_i, fetch_pc4_i, mem_rdata_i, flush_i, dec_ready_i,
      output fetch_hold_o, dec_valid_o, dec_instr_o, dec_pc_o, dec_pc4_o,
             overflow_o, perf_hold_cnt_o, perf_flush_cnt_o
   );

   modport master (
      output fetch_valid_i, fetch_pc_i, fetch_pc4_i, mem_rdata_i, flush_i, dec_ready_i,
      input  fetch_hold_o, dec_valid_o, dec_instr_o, dec_pc_o, dec_pc4_o,
             overflow_o, perf_hold_cnt_o, perf_flush_cnt_o
   );

endinterface : instr_buf_if
`default_nettype wire

// File: rtl/instr_buf_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : instr_buf_fifo                                                |
// | Purpose    : Storage array with read/write pointers and occupancy count.   |
// |              Head entry is read combinationally from storage.             |
// | Ports      : clk_i, rst_i (sync, active-high)                              |
// |              clear    - discard everything, pointers back to 0            |
// |              push     - write wr_entry (ignored when full without a pop)  |
// |              pop      - retire head entry (ignored when empty)            |
// |              wr_entry - entry to write                                    |
// |              head     - entry at rd_ptr                                   |
// |              count    - number of stored entries (log2(DEPTH)+1 bits)     |
// |              full, empty                                                  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module instr_buf_fifo
   import instr_buf_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  wire logic                   clk_i,
   input  wire logic                   rst_i,
   input  wire logic                   clear,
   input  wire logic                   push,
   input  wire logic                   pop,
   input  wire fetch_entry_t           wr_entry,
   output fetch_entry_t                head,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        full,
   output logic                        empty
);

   localparam int              PW       = $clog2(DEPTH);
   localparam int              CW       = PW + 1;
   localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // A pop frees the head slot in the same cycle, so a push at full is
   // accepted when paired with a pop.
   assign do_push = push & ~clear & (~full | pop);
   assign do_pop  = pop  & ~clear & ~empty;

   assign head = mem[rd_ptr];

   // Storage needs no reset: contents are only observed behind count != 0.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Pointers are log2(DEPTH) wide so they wrap without compare logic.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

endmodule : instr_buf_fifo
`default_nettype wire

// File: rtl/instr_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : instr_buffer                                                  |
// | Purpose    : Decoupling buffer between fetch and decode. Captures each     |
// |              fetched word with its PC/PC+4, presents entries in order via  |
// |              valid/ready, raises the fetch hold request, flushes on        |
// |              redirect and squashes the in-flight wrong-path word.          |
// | Params     : DEPTH       - entries (power of two, >= 2)                    |
// |              SQUASH_SLOT - 1: drop first fetch word after a flush          |
// | Ports      : clk_i, rst_i (sync, active-high), bus (instr_buf_if.slave)    |
// | Config     : INSTR_BUF_PERF_EN - builds the hold/flush cycle counters;     |
// |              when undefined both counter ports read 0.                     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module instr_buffer
   import instr_buf_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter bit SQUASH_SLOT = 1'b1
) (
   input  wire logic     clk_i,
   input  wire logic     rst_i,
   instr_buf_if.slave    bus
);

   localparam int             CW       = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]  HOLD_CNT = CW'(DEPTH - 1);

   fetch_entry_t   wr_entry;
   fetch_entry_t   head;
   logic [CW-1:0]  count;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           dec_valid;
   logic           hold;
   logic           squash_pend;
   logic           overflow;

   assign wr_entry = '{pc: bus.fetch_pc_i, pc4: bus.fetch_pc4_i, instr: bus.mem_rdata_i};

   assign push      = bus.fetch_valid_i & ~bus.flush_i & ~squash_pend;
   assign dec_valid = ~empty & ~bus.flush_i;
   assign pop       = dec_valid & bus.dec_ready_i;

   // Registered count only: hold never depends combinationally on decode
   // ready, and raising it one entry early leaves a slot for the word
   // already in flight from memory.
   assign hold = (count >= HOLD_CNT);

   instr_buf_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear    (bus.flush_i),
      .push     (push),
      .pop      (pop),
      .wr_entry (wr_entry),
      .head     (head),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   // Sticky overflow: a push that the FIFO had to drop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overflow <= 1'b0;
      end else if (push && full && !pop) begin
         overflow <= 1'b1;
      end
   end

   // The word fetched on the wrong path is still returning when the
   // redirect lands; the first fetch_valid_i after a flush is that word.
   generate
      if (SQUASH_SLOT) begin : g_squash
         logic squash_q;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               squash_q <= 1'b0;
            end else if (bus.flush_i) begin
               squash_q <= 1'b1;
            end else if (bus.fetch_valid_i) begin
               squash_q <= 1'b0;
            end
         end
         assign squash_pend = squash_q;
      end else begin : g_no_squash
         assign squash_pend = 1'b0;
      end
   endgenerate

`ifdef INSTR_BUF_PERF_EN
   logic [31:0] perf_hold_cnt;
   logic [31:0] perf_flush_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_hold_cnt  <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (hold) begin
            perf_hold_cnt <= perf_hold_cnt + 32'd1;
         end
         if (bus.flush_i) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end

   assign bus.perf_hold_cnt_o  = perf_hold_cnt;
   assign bus.perf_flush_cnt_o = perf_flush_cnt;
`else
   assign bus.perf_hold_cnt_o  = 32'd0;
   assign bus.perf_flush_cnt_o = 32'd0;
`endif

   assign bus.fetch_hold_o = hold;
   assign bus.dec_valid_o  = dec_valid;
   assign bus.dec_instr_o  = head.instr;
   assign bus.dec_pc_o     = head.pc;
   assign bus.dec_pc4_o    = head.pc4;
   assign bus.overflow_o   = overflow;

endmodule : instr_buffer
`default_nettype wire

// File: tb/tb_instr_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_instr_buffer                                               |
// | Purpose    : Directed self-checking bench for instr_buffer (DEPTH=2,       |
// |              SQUASH_SLOT=1). Inputs change 1 time unit after the rising    |
// |              edge; outputs are checked before the next rising edge.        |
// | Config     : INSTR_BUF_PERF_EN selects the expected perf counter values.   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instr_buffer;

`ifdef INSTR_BUF_PERF_EN
   localparam logic [31:0] EXP_HOLD  = 32'd3;
   localparam logic [31:0] EXP_FLUSH = 32'd2;
`else
   localparam logic [31:0] EXP_HOLD  = 32'd0;
   localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;

   instr_buf_if bus ();

   instr_buffer #(
      .DEPTH       (2),
      .SQUASH_SLOT (1'b1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a fetch beat (valid=0 idles the fetch side).
   task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] instr);
      bus.fetch_valid_i = v;
      bus.fetch_pc_i    = pc;
      bus.fetch_pc4_i   = pc + 32'd4;
      bus.mem_rdata_i   = instr;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.flush_i     = 1'b0;
      bus.dec_ready_i = 1'b0;
      fetch(1'b0, 32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      settle();

      // reset state
      check("rst_valid",    {31'd0, bus.dec_valid_o},  32'd0);
      check("rst_hold",     {31'd0, bus.fetch_hold_o}, 32'd0);
      check("rst_overflow", {31'd0, bus.overflow_o},   32'd0);
      check("rst_perf_hold",  bus.perf_hold_cnt_o,  32'd0);
      check("rst_perf_flush", bus.perf_flush_cnt_o, 32'd0);

      // single push, visible one cycle later, consumed immediately
      bus.dec_ready_i = 1'b1;
      fetch(1'b1, 32'h100, 32'h0000_0013);
      settle();
      check("t1_no_bypass", {31'd0, bus.dec_valid_o}, 32'd0);
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      settle();
      check("t1_valid", {31'd0, bus.dec_valid_o}, 32'd1);
      check("t1_pc",    bus.dec_pc_o,    32'h100);
      check("t1_pc4",   bus.dec_pc4_o,   32'h104);
      check("t1_instr", bus.dec_instr_o, 32'h0000_0013);
      tick();
      check("t1_empty", {31'd0, bus.dec_valid_o}, 32'd0);

      // fill with decode stalled, then drain in order
      bus.dec_ready_i = 1'b0;
      fetch(1'b1, 32'h100, 32'h0000_000A);
      tick();
      fetch(1'b1, 32'h104, 32'h0000_000B);
      settle();
      check("t2_hold_after_1", {31'd0, bus.fetch_hold_o}, 32'd1);
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      settle();
      check("t2_hold_full", {31'd0, bus.fetch_hold_o}, 32'd1);
      check("t2_head0_pc",  bus.dec_pc_o, 32'h100);
      bus.dec_ready_i = 1'b1;
      tick();
      check("t2_head1_pc",    bus.dec_pc_o,    32'h104);
      check("t2_head1_instr", bus.dec_instr_o, 32'h0000_000B);
      tick();
      check("t2_drained", {31'd0, bus.dec_valid_o}, 32'd0);
      check("t2_no_ovf",  {31'd0, bus.overflow_o},  32'd0);

      // full, then simultaneous push and pop
      bus.dec_ready_i = 1'b0;
      fetch(1'b1, 32'h300, 32'h0000_0030);
      tick();
      fetch(1'b1, 32'h304, 32'h0000_0031);
      tick();
      fetch(1'b1, 32'h308, 32'h0000_0032);
      bus.dec_ready_i = 1'b1;
      settle();
      check("t3_head_before", bus.dec_pc_o, 32'h300);
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      bus.dec_ready_i = 1'b0;
      settle();
      check("t3_head_after", bus.dec_pc_o, 32'h304);
      check("t3_still_full", {31'd0, bus.fetch_hold_o}, 32'd1);
      check("t3_no_ovf",     {31'd0, bus.overflow_o},   32'd0);

      // flush with two entries queued and a concurrent fetch
      bus.flush_i = 1'b1;
      fetch(1'b1, 32'h400, 32'h0000_0040);
      settle();
      check("t4_valid_in_flush", {31'd0, bus.dec_valid_o}, 32'd0);
      tick();
      bus.flush_i = 1'b0;
      fetch(1'b0, 32'h0, 32'h0);
      settle();
      check("t4_valid_after", {31'd0, bus.dec_valid_o},  32'd0);
      check("t4_hold_after",  {31'd0, bus.fetch_hold_o}, 32'd0);
      fetch(1'b1, 32'h500, 32'h0000_0050);
      tick();
      fetch(1'b1, 32'h200, 32'h0000_0022);
      settle();
      check("t4_squashed", {31'd0, bus.dec_valid_o}, 32'd0);
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      settle();
      check("t4_valid_200", {31'd0, bus.dec_valid_o}, 32'd1);
      check("t4_pc_200",    bus.dec_pc_o,    32'h200);
      check("t4_instr_200", bus.dec_instr_o, 32'h0000_0022);
      bus.dec_ready_i = 1'b1;
      tick();
      check("t4_drained", {31'd0, bus.dec_valid_o}, 32'd0);

      // overflow: third push into a full buffer without a pop
      bus.dec_ready_i = 1'b0;
      fetch(1'b1, 32'h600, 32'h0000_0061);
      tick();
      fetch(1'b1, 32'h604, 32'h0000_0062);
      tick();
      check("t5_no_ovf_yet", {31'd0, bus.overflow_o}, 32'd0);
      fetch(1'b1, 32'h608, 32'h0000_0063);
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      settle();
      check("t5_ovf",         {31'd0, bus.overflow_o}, 32'd1);
      check("t5_head0_pc",    bus.dec_pc_o,    32'h600);
      check("t5_head0_instr", bus.dec_instr_o, 32'h0000_0061);
      bus.dec_ready_i = 1'b1;
      tick();
      check("t5_head1_pc",    bus.dec_pc_o,    32'h604);
      check("t5_head1_instr", bus.dec_instr_o, 32'h0000_0062);
      tick();
      check("t5_empty",       {31'd0, bus.dec_valid_o}, 32'd0);
      check("t5_ovf_sticky",  {31'd0, bus.overflow_o},  32'd1);

      // reset mid-operation overrides flush and push
      bus.dec_ready_i = 1'b0;
      fetch(1'b1, 32'h700, 32'h0000_0070);
      tick();
      rst = 1'b1;
      bus.flush_i = 1'b1;
      tick();
      rst = 1'b0;
      bus.flush_i = 1'b0;
      fetch(1'b0, 32'h0, 32'h0);
      settle();
      check("t6_valid",    {31'd0, bus.dec_valid_o},  32'd0);
      check("t6_hold",     {31'd0, bus.fetch_hold_o}, 32'd0);
      check("t6_overflow", {31'd0, bus.overflow_o},   32'd0);
      check("t6_perf_hold",  bus.perf_hold_cnt_o,  32'd0);
      check("t6_perf_flush", bus.perf_flush_cnt_o, 32'd0);

      // perf: hold high for 3 cycles, 2 flush cycles
      fetch(1'b1, 32'h800, 32'h0000_0080);
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      tick();
      tick();
      bus.flush_i = 1'b1;
      tick();
      tick();
      bus.flush_i = 1'b0;
      settle();
      check("t7_hold_low",    {31'd0, bus.fetch_hold_o}, 32'd0);
      check("t7_perf_hold",   bus.perf_hold_cnt_o,  EXP_HOLD);
      check("t7_perf_flush",  bus.perf_flush_cnt_o, EXP_FLUSH);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_instr_buffer
`default_nettype wire
